reg_write_strobe: RTL and testbench

//  Bus-side producer of write clocks for the GSTMCU register file. Takes an asynchronous 68000-style

---
 rtl/gstmcu_pkg.sv | 20 ++
 rtl/reg_write_strobe_if.sv | 31 +++
 rtl/reg_write_strobe_sync2.sv | 24 ++
 rtl/reg_write_strobe.sv | 129 ++++++++++++
 tb/tb_reg_write_strobe.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/gstmcu_pkg.sv
// Shared GSTMCU constants: default register-file geometry and the write-strobe FSM encoding.
package gstmcu_pkg;

  localparam int NREGS_DEF = 8;
  localparam int AW_DEF    = 3;
  localparam int DW_DEF    = 16;

  // Prefixed so the literals never collide with the SETUP/PULSE timing parameters.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_ACK   = 2'd3
  } wsState_e;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reg_write_strobe_if.sv
// 68000-side write bus and register-file strobe outputs of reg_write_strobe.
interface reg_write_strobe_if #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 16
);

  logic             cs;
  logic             as_n;
  logic             rw;
  logic             uds_n;
  logic             lds_n;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    din;
  logic [DW-1:0]    wdata;
  logic [1:0]       byte_en;
  logic [NREGS-1:0] wstrobe;
  logic             dtack_n;
  logic             busy;

  modport master (
    output cs, as_n, rw, uds_n, lds_n, addr, din,
    input  wdata, byte_en, wstrobe, dtack_n, busy
  );

  modport slave (
    input  cs, as_n, rw, uds_n, lds_n, addr, din,
    output wdata, byte_en, wstrobe, dtack_n, busy
  );

endinterface

// File: rtl/reg_write_strobe_sync2.sv
// Two-flop synchroniser; resets to 1 so active-low strobes read as idle out of reset.
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reg_write_strobe.sv
// Turns an asynchronous 68000 write cycle into a one-hot register write clock of fixed width,
// with write data held stable around it, then returns DTACK to the CPU.
module reg_write_strobe
  import gstmcu_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int SETUP = 1,
  parameter int PULSE = 2
) (
  input logic               clock,
  input logic               reset,
  reg_write_strobe_if.slave bus
);

  localparam int CW = $clog2(maxInt(SETUP, PULSE) + 1);

  logic asS, udsS, ldsS, csS;
  logic ds, req;

  wsState_e         state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [AW-1:0]    addr_q,    addr_d;
  logic [DW-1:0]    wdata_q,   wdata_d;
  logic [1:0]       byteEn_q,  byteEn_d;
  logic [NREGS-1:0] wstrobe_q, wstrobe_d;
  logic             dtackN_q,  dtackN_d;
  logic             abort_q,   abort_d;

  sync2 uAsSync  (.clock(clock), .reset(reset), .d_i(bus.as_n),  .q_o(asS));
  sync2 uUdsSync (.clock(clock), .reset(reset), .d_i(bus.uds_n), .q_o(udsS));
  sync2 uLdsSync (.clock(clock), .reset(reset), .d_i(bus.lds_n), .q_o(ldsS));
  sync2 uCsSync  (.clock(clock), .reset(reset), .d_i(bus.cs),    .q_o(csS));

  // rw is taken raw: the CPU holds it stable for as long as the strobes stay low.
  assign ds  = ~udsS | ~ldsS;
  assign req = ~asS & csS & ds & ~bus.rw;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      byteEn_q  <= '0;
      wstrobe_q <= '0;
      dtackN_q  <= 1'b1;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      byteEn_q  <= byteEn_d;
      wstrobe_q <= wstrobe_d;
      dtackN_q  <= dtackN_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    byteEn_d  = byteEn_q;
    wstrobe_d = wstrobe_q;
    dtackN_d  = dtackN_q;
    abort_d   = abort_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d   = bus.addr;
          wdata_d  = bus.din;
          byteEn_d = {~udsS, ~ldsS};
          cnt_d    = CW'(SETUP);
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        if (asS) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(1)) begin
          // An out-of-range index decodes to no strobe but still completes the handshake.
          for (int i = 0; i < NREGS; i++) begin
            wstrobe_d[i] = (addr_q == AW'(i));
          end
          cnt_d   = CW'(PULSE);
          abort_d = 1'b0;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // Once the strobe has risen it always runs its full width; a CPU abort only suppresses the ack.
      S_PULSE: begin
        if (cnt_q == CW'(1)) begin
          wstrobe_d = '0;
          state_d   = (abort_q | asS) ? S_IDLE : S_ACK;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          abort_d = abort_q | asS;
        end
      end

      S_ACK: begin
        if (dtackN_q) begin
          dtackN_d = 1'b0;
        end else if (asS & udsS & ldsS) begin
          dtackN_d = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.wdata   = wdata_q;
  assign bus.byte_en = byteEn_q;
  assign bus.wstrobe = wstrobe_q;
  assign bus.dtack_n = dtackN_q;
  assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_write_strobe.sv
// Bench for reg_write_strobe: an 8-register and a 6-register instance share one CPU bus and are
// checked every cycle against a timeline model of the write cycle.
module tb_reg_write_strobe;

  localparam int SETUP_C = 1;
  localparam int PULSE_C = 2;
  localparam int CAP     = 3;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] modelWdata = '0;
  logic [1:0]  modelBe    = '0;

  reg_write_strobe_if #(.NREGS(8), .AW(3), .DW(16)) bus8 ();
  reg_write_strobe_if #(.NREGS(6), .AW(3), .DW(16)) bus6 ();

  assign bus6.cs    = bus8.cs;
  assign bus6.as_n  = bus8.as_n;
  assign bus6.rw    = bus8.rw;
  assign bus6.uds_n = bus8.uds_n;
  assign bus6.lds_n = bus8.lds_n;
  assign bus6.addr  = bus8.addr;
  assign bus6.din   = bus8.din;

  reg_write_strobe #(.NREGS(8), .AW(3), .DW(16), .SETUP(SETUP_C), .PULSE(PULSE_C))
    dut8 (.clock(clock), .reset(reset), .bus(bus8));
  reg_write_strobe #(.NREGS(6), .AW(3), .DW(16), .SETUP(SETUP_C), .PULSE(PULSE_C))
    dut6 (.clock(clock), .reset(reset), .bus(bus6));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic [15:0] din;
    bit          udsLow;
    bit          ldsLow;
    bit          rw;
    bit          cs;
    int          hold;
    logic [7:0]  exp8;
    logic [7:0]  exp6;
    int          expLen;
    bit          expAck8;
    bit          expAck6;
    logic [15:0] expData;
  } vec_t;

  function automatic logic [31:0] packOut(input logic [7:0] s, input logic [15:0] w,
                                          input logic [1:0] b, input logic d, input logic bz);
    return {4'b0, s, w, b, d, bz};
  endfunction

  function automatic logic [31:0] got8();
    return packOut(bus8.wstrobe, bus8.wdata, bus8.byte_en, bus8.dtack_n, bus8.busy);
  endfunction

  function automatic logic [31:0] got6();
    return packOut({2'b00, bus6.wstrobe}, bus6.wdata, bus6.byte_en, bus6.dtack_n, bus6.busy);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drives one CPU cycle (strobes low for 'hold' edges) and checks both DUTs every cycle.
  task automatic applyStimulus(input vec_t v, output logic [7:0] seen8, output logic [7:0] seen6,
                               output int pulseLen, output bit ack8, output bit ack6,
                               output logic [15:0] dataSeen);
    int  r        = 1 + v.hold;
    bit  isWrite  = !v.rw && v.cs && (v.udsLow || v.ldsLow);
    bit  abortS   = isWrite && (r + 2 <= CAP + SETUP_C);
    bit  strobeOn = isWrite && !abortS;
    bit  abortP   = strobeOn && (r + 2 <= CAP + SETUP_C + PULSE_C);
    bit  ackOn    = strobeOn && !abortP;
    int  ackStart = CAP + SETUP_C + PULSE_C + 1;
    int  ackEnd   = (r + 2 > ackStart + 1) ? r + 2 : ackStart + 1;
    int  busyEnd;
    int  last;
    logic [7:0] s8, s6;
    logic dt, bz;
    busyEnd = !isWrite ? 0 : abortS ? r + 2 : abortP ? CAP + SETUP_C + PULSE_C : ackEnd;
    last    = ((busyEnd > r + 2) ? busyEnd : r + 2) + 2;
    seen8 = '0; seen6 = '0; pulseLen = 0; ack8 = 0; ack6 = 0; dataSeen = '0;
    bus8.rw    = v.rw;
    bus8.cs    = v.cs;
    bus8.addr  = v.addr;
    bus8.din   = v.din;
    bus8.uds_n = !v.udsLow;
    bus8.lds_n = !v.ldsLow;
    bus8.as_n  = 1'b0;
    for (int i = 1; i <= last; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (isWrite && i == CAP) begin
        modelWdata = v.din;
        modelBe    = {v.udsLow, v.ldsLow};
      end
      s8 = (strobeOn && i >= CAP + SETUP_C && i < CAP + SETUP_C + PULSE_C) ? (8'd1 << v.addr) : 8'd0;
      s6 = (v.addr < 3'd6) ? s8 : 8'd0;
      dt = !(ackOn && i >= ackStart && i < ackEnd);
      bz = isWrite && i >= CAP && i < busyEnd;
      checkOutput($sformatf("%s.dut8.c%0d", v.name, i), got8(), packOut(s8, modelWdata, modelBe, dt, bz));
      checkOutput($sformatf("%s.dut6.c%0d", v.name, i), got6(), packOut(s6, modelWdata, modelBe, dt, bz));
      seen8 |= bus8.wstrobe;
      seen6 |= {2'b00, bus6.wstrobe};
      if (bus8.wstrobe != '0) begin
        pulseLen++;
        dataSeen = bus8.wdata;
      end
      ack8 |= !bus8.dtack_n;
      ack6 |= !bus6.dtack_n;
      if (i + 1 == r) begin
        bus8.as_n  = 1'b1;
        bus8.uds_n = 1'b1;
        bus8.lds_n = 1'b1;
      end
    end
  endtask

  vec_t        vecs[$];
  vec_t        v;
  logic [7:0]  seen8, seen6;
  int          pulseLen;
  bit          ack8, ack6;
  logic [15:0] dataSeen;

  initial begin
    vecs.push_back('{"write3",     3'd3, 16'hA55A, 1, 1, 0, 1, 6, 8'h08, 8'h08, 2, 1, 1, 16'hA55A});
    vecs.push_back('{"ldsOnly0",   3'd0, 16'h00FF, 0, 1, 0, 1, 6, 8'h01, 8'h01, 2, 1, 1, 16'h00FF});
    vecs.push_back('{"read2",      3'd2, 16'h1234, 1, 1, 1, 1, 6, 8'h00, 8'h00, 0, 0, 0, 16'h0000});
    vecs.push_back('{"abortSetup", 3'd5, 16'hBEEF, 1, 1, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0, 16'h0000});
    vecs.push_back('{"abortPulse", 3'd5, 16'hCAFE, 1, 1, 0, 1, 2, 8'h20, 8'h20, 2, 0, 0, 16'hCAFE});
    vecs.push_back('{"abortLate",  3'd2, 16'h5A5A, 0, 1, 0, 1, 3, 8'h04, 8'h04, 2, 0, 0, 16'h5A5A});
    vecs.push_back('{"addr7",      3'd7, 16'h1357, 1, 1, 0, 1, 6, 8'h80, 8'h00, 2, 1, 1, 16'h1357});
    vecs.push_back('{"csLow",      3'd1, 16'h4444, 1, 1, 0, 0, 5, 8'h00, 8'h00, 0, 0, 0, 16'h0000});
    vecs.push_back('{"udsOnly6",   3'd6, 16'hAB00, 1, 0, 0, 1, 4, 8'h40, 8'h00, 2, 1, 1, 16'hAB00});

    reset      = 1'b1;
    bus8.as_n  = 1'b1;
    bus8.uds_n = 1'b1;
    bus8.lds_n = 1'b1;
    bus8.rw    = 1'b1;
    bus8.cs    = 1'b0;
    bus8.addr  = '0;
    bus8.din   = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset.dut8", got8(), packOut(8'h00, 16'h0000, 2'b00, 1'b1, 1'b0));
    checkOutput("reset.dut6", got6(), packOut(8'h00, 16'h0000, 2'b00, 1'b1, 1'b0));
    reset = 1'b0;
    repeat (3) @(negedge clock);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k], seen8, seen6, pulseLen, ack8, ack6, dataSeen);
      checkOutput({vecs[k].name, ".strobe8"}, 32'(seen8), 32'(vecs[k].exp8));
      checkOutput({vecs[k].name, ".strobe6"}, 32'(seen6), 32'(vecs[k].exp6));
      checkOutput({vecs[k].name, ".width"}, 32'(pulseLen), 32'(vecs[k].expLen));
      checkOutput({vecs[k].name, ".ack8"}, 32'(ack8), 32'(vecs[k].expAck8));
      checkOutput({vecs[k].name, ".ack6"}, 32'(ack6), 32'(vecs[k].expAck6));
      if (vecs[k].expLen > 0)
        checkOutput({vecs[k].name, ".regData"}, 32'(dataSeen), 32'(vecs[k].expData));
    end

    // Reset while register 4 is being strobed: everything must drop immediately.
    bus8.rw    = 1'b0;
    bus8.cs    = 1'b1;
    bus8.addr  = 3'd4;
    bus8.din   = 16'h7E7E;
    bus8.uds_n = 1'b0;
    bus8.lds_n = 1'b0;
    bus8.as_n  = 1'b0;
    repeat (CAP + SETUP_C) begin
      @(posedge clock);
      @(negedge clock);
    end
    checkOutput("midPulse.strobe", 32'(bus8.wstrobe), 32'h10);
    reset = 1'b1;
    #1;
    checkOutput("midReset.dut8", got8(), packOut(8'h00, 16'h0000, 2'b00, 1'b1, 1'b0));
    checkOutput("midReset.dut6", got6(), packOut(8'h00, 16'h0000, 2'b00, 1'b1, 1'b0));
    bus8.as_n  = 1'b1;
    bus8.uds_n = 1'b1;
    bus8.lds_n = 1'b1;
    modelWdata = '0;
    modelBe    = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput($sformatf("postReset.c%0d", i), got8(), packOut(8'h00, 16'h0000, 2'b00, 1'b1, 1'b0));
    end
    v = '{"afterReset", 3'd1, 16'h0F0F, 1, 1, 0, 1, 5, 8'h02, 8'h02, 2, 1, 1, 16'h0F0F};
    applyStimulus(v, seen8, seen6, pulseLen, ack8, ack6, dataSeen);
    checkOutput("afterReset.strobe8", 32'(seen8), 32'h02);
    checkOutput("afterReset.width", 32'(pulseLen), 32'd2);
    checkOutput("afterReset.ack8", 32'(ack8), 32'd1);

    for (int n = 0; n < 40; n++) begin
      v.name    = $sformatf("rand%0d", n);
      v.addr    = 3'($urandom_range(0, 7));
      v.din     = 16'($urandom);
      v.udsLow  = ($urandom_range(0, 3) != 0);
      v.ldsLow  = ($urandom_range(0, 3) != 0);
      v.rw      = ($urandom_range(0, 3) == 0);
      v.cs      = ($urandom_range(0, 7) != 0);
      v.hold    = int'($urandom_range(1, 8));
      applyStimulus(v, seen8, seen6, pulseLen, ack8, ack6, dataSeen);
      repeat (int'($urandom_range(0, 2))) @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
